multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Moore FSM sequencing the multicycle MIPS datapath; directly upstream of the ALU, driving ALU_Control and operand selects.
//  Decodes OPCODE/FUNCT from the instruction register; stalls on MEM_READY; consumes ZERO_Flag for beq.
//  Also emits an illegal-instruction pulse and a retired-instruction counter.
// PARAMETERS
//  OPCODE_WIDTH      6   instruction opcode field width
//  FUNCT_WIDTH       6   R-type funct field width
//  ALUControl_WIDTH  3   ALU operation select width
//  COUNT_WIDTH       32  retired-instruction counter width
// PORTS
//  CLK          in   1   single clock, rising edge
//  RST          in   1   asynchronous, active-high reset
//  OPCODE       in   6   IR[31:26]
//  FUNCT        in   6   IR[5:0]
//  ZERO_Flag    in   1   ALU zero result
//  MEM_READY    in   1   memory access completes this cycle
//  IorD         out  1   memory address select: 0 PC, 1 ALUOut
//  MemWrite     out  1   data memory write enable
//  IRWrite      out  1   instruction register load
//  RegDst       out  1   write register: 0 rt, 1 rd
//  MemtoReg     out  1   write-back data: 0 ALUOut, 1 MDR
//  RegWrite     out  1   register file write enable
//  ALUSrcA      out  1   0 PC, 1 register A
//  ALUSrcB      out  2   00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  ALU_Control  out  3   000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT
//  PCSrc        out  2   00 ALUResult, 01 ALUOut, 10 jump target
//  PCEn         out  1   PCWrite | (Branch & ZERO_Flag)
//  ILLEGAL_OP   out  1   one-cycle pulse on unknown opcode/funct
//  STATE        out  4   current state (debug)
//  INSTR_COUNT  out  32  retired instructions, wraps modulo 2^COUNT_WIDTH
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
//  Outputs are combinational from STATE (plus MEM_READY/ZERO_Flag where noted); unlisted outputs default 0 with ALU_Control=010.
//  RST high: STATE=FETCH, INSTR_COUNT=0, ILLEGAL_OP=0; all enables (IRWrite, PCEn, MemWrite, RegWrite) forced 0 while RST is high.
//  Reset mid-instruction abandons it; the counter does not increment.
//  FETCH: ALUSrcB=01, ADD, IRWrite=PCWrite=MEM_READY; holds until MEM_READY, then DECODE.
//  DECODE: ALUSrcB=11, ADD. lw(100011)/sw(101011)->MEMADR; R(000000)->EXECUTE; beq(000100)->BRANCH; addi(001000)->ADDIEXEC;
//    j(000010)->JUMP; any other opcode->FETCH with ILLEGAL_OP=1 for exactly one cycle.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: IorD=1; holds until MEM_READY, then MEMWB. MEMWB: MemtoReg=1, RegWrite=1 -> FETCH.
//  MEMWRITE: IorD=1, MemWrite=1 for every wait cycle; on MEM_READY -> FETCH.
//  EXECUTE: ALUSrcA=1, ALUSrcB=00; funct 100000->010, 100010->100, 100100->000, 100101->001, 101010->110, 011000->101 -> ALUWB.
//    Unknown funct: ALU_Control=011, ILLEGAL_OP pulse, -> FETCH with no writeback.
//  ALUWB: RegDst=1, RegWrite=1 -> FETCH.
//  BRANCH: ALUSrcA=1, SUB, PCSrc=01, Branch=1 (PCEn=ZERO_Flag) -> FETCH.
//  ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB. ADDIWB: RegWrite=1 -> FETCH.
//  JUMP: PCSrc=10, PCWrite=1 -> FETCH.
//  INSTR_COUNT += 1 on each legal transition into FETCH (from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP); illegal paths do not count.
//  Cycle counts at MEM_READY=1: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
// STRUCTURE
//  Shared package mips_pkg: state encodings, opcode/funct constants, ALU_Control codes (shared with the ALU), ALUSrcB/PCSrc encodings.
//  One sub-module: alu_decoder (combinational FUNCT -> ALU_Control + funct_illegal); registered state, ILLEGAL_OP and counter live in the top.
// TESTING
//  RST pulse mid-MEMREAD -> STATE=FETCH asynchronously, all enables 0 while high, INSTR_COUNT=0.
//  lw with MEM_READY low 2 cycles in FETCH and MEMREAD -> 9 cycles total, one RegWrite cycle with MemtoReg=1, count +1.
//  R-type sub (funct 100010) -> ALU_Control=100 in EXECUTE, RegDst=1/RegWrite=1 in ALUWB; funct 101010 -> 110.
//  beq with ZERO_Flag=1 -> PCEn=1 in BRANCH; ZERO_Flag=0 -> PCEn=0; count +1 in both cases.
//  Opcode 111111 -> DECODE->FETCH, ILLEGAL_OP high exactly 1 cycle, count unchanged; R-type funct 000000 behaves the same.
//  Preload count to 2^32-1 via run, then j -> INSTR_COUNT wraps to 0; sw with MEM_READY held low 3 cycles -> MemWrite held 4 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encodings,
// opcode/funct constants, ALU operation codes and datapath select encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  // ALU operation codes, shared with the ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ILL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: maps FUNCT to an ALU operation and
// flags funct values the datapath does not implement.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_funct_illegal
);

  // Funct lookup; unknown codes select the reserved ALU op and raise the flag
  always_comb begin
    o_alu_control   = ALU_ILL;
    o_funct_illegal = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_control = ALU_ADD;
      FN_SUB:  o_alu_control = ALU_SUB;
      FN_AND:  o_alu_control = ALU_AND;
      FN_OR:   o_alu_control = ALU_OR;
      FN_SLT:  o_alu_control = ALU_SLT;
      FN_MUL:  o_alu_control = ALU_MUL;
      default: begin
        o_alu_control   = ALU_ILL;
        o_funct_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath. Outputs decode from the
// current state (plus MEM_READY in FETCH and ZERO_Flag in BRANCH); the state,
// the illegal-instruction pulse and the retired-instruction counter are registered.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int OPCODE_WIDTH     = 6,
  parameter int FUNCT_WIDTH      = 6,
  parameter int ALUControl_WIDTH = 3,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [OPCODE_WIDTH-1:0]     OPCODE,
  input  logic [FUNCT_WIDTH-1:0]      FUNCT,
  input  logic                        ZERO_Flag,
  input  logic                        MEM_READY,
  output logic                        IorD,
  output logic                        MemWrite,
  output logic                        IRWrite,
  output logic                        RegDst,
  output logic                        MemtoReg,
  output logic                        RegWrite,
  output logic                        ALUSrcA,
  output logic [1:0]                  ALUSrcB,
  output logic [ALUControl_WIDTH-1:0] ALU_Control,
  output logic [1:0]                  PCSrc,
  output logic                        PCEn,
  output logic                        ILLEGAL_OP,
  output logic [3:0]                  STATE,
  output logic [COUNT_WIDTH-1:0]      INSTR_COUNT
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_illegal;
  logic [COUNT_WIDTH-1:0] r_count;

  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_srca, w_pcwrite, w_branch, w_illegal, w_retire;
  logic [1:0] w_srcb, w_pcsrc;
  logic [2:0] w_alu_control;
  logic [2:0] w_dec_alu;
  logic       w_dec_illegal;

  alu_decoder u_alu_decoder (
    .i_funct         (FUNCT),
    .o_alu_control   (w_dec_alu),
    .o_funct_illegal (w_dec_illegal)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Illegal pulse is high for the one cycle after the illegal decode/execute
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_illegal <= 1'b0;
    else     r_illegal <= w_illegal;
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_count <= '0;
    else if (w_retire) r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    else               r_count <= r_count;
  end

  // Next-state and per-state control decode; everything defaults to idle/ADD
  always_comb begin
    w_next        = r_state;
    w_iord        = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_regdst      = 1'b0;
    w_memtoreg    = 1'b0;
    w_regwrite    = 1'b0;
    w_srca        = 1'b0;
    w_srcb        = SRCB_REG;
    w_alu_control = ALU_ADD;
    w_pcsrc       = PC_ALURES;
    w_pcwrite     = 1'b0;
    w_branch      = 1'b0;
    w_illegal     = 1'b0;
    w_retire      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_srcb    = SRCB_FOUR;
        w_irwrite = MEM_READY;
        w_pcwrite = MEM_READY;
        if (MEM_READY) w_next = S_DECODE;
        else           w_next = S_FETCH;
      end
      S_DECODE: begin
        w_srcb = SRCB_IMMSH;
        case (OPCODE)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_srca = 1'b1;
        w_srcb = SRCB_IMM;
        // IR is stable for the whole instruction, so the opcode still tells lw from sw
        if (OPCODE == OP_SW) w_next = S_MEMWRITE;
        else                 w_next = S_MEMREAD;
      end
      S_MEMREAD: begin
        w_iord = 1'b1;
        if (MEM_READY) w_next = S_MEMWB;
        else           w_next = S_MEMREAD;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (MEM_READY) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next   = S_MEMWRITE;
        end
      end
      S_EXECUTE: begin
        w_srca        = 1'b1;
        w_srcb        = SRCB_REG;
        w_alu_control = w_dec_alu;
        if (w_dec_illegal) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next    = S_ALUWB;
        end
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_srca        = 1'b1;
        w_alu_control = ALU_SUB;
        w_pcsrc       = PC_ALUOUT;
        w_branch      = 1'b1;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_ADDIEXEC: begin
        w_srca = 1'b1;
        w_srcb = SRCB_IMM;
        w_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = PC_JUMP;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are gated by RST so nothing writes while reset is asserted
  assign IorD        = w_iord;
  assign MemWrite    = w_memwrite & ~RST;
  assign IRWrite     = w_irwrite & ~RST;
  assign RegDst      = w_regdst;
  assign MemtoReg    = w_memtoreg;
  assign RegWrite    = w_regwrite & ~RST;
  assign ALUSrcA     = w_srca;
  assign ALUSrcB     = w_srcb;
  assign ALU_Control = w_alu_control;
  assign PCSrc       = w_pcsrc;
  assign PCEn        = (w_pcwrite | (w_branch & ZERO_Flag)) & ~RST;
  assign ILLEGAL_OP  = r_illegal;
  assign STATE       = r_state;
  assign INSTR_COUNT = r_count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit. Each instruction is
// expanded into the list of phases it must walk through; every cycle the DUT state
// and controls are compared against the expected phase. A second instance with a
// 4-bit counter exercises counter wrap-around in a short run.
module tb_multicycle_control_unit;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_EX = 6, P_AWB = 7, P_BR = 8, P_AE = 9, P_AIWB = 10, P_J = 11;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

  typedef struct { int ph; logic mr; } phase_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  OPCODE, FUNCT;
  logic        ZERO_Flag, MEM_READY;
  logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, ILLEGAL_OP;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALU_Control;
  logic [3:0]  STATE;
  logic [31:0] INSTR_COUNT;

  logic        s_iord, s_memwrite, s_irwrite, s_regdst, s_memtoreg, s_regwrite, s_srca, s_pcen, s_ill;
  logic [1:0]  s_srcb, s_pcsrc;
  logic [2:0]  s_alu;
  logic [3:0]  s_state;
  logic [3:0]  s_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_count = 32'd0;
  logic        ill_pending = 1'b0;
  logic [2:0]  fn_tab [logic [5:0]];
  phase_t      q[$];

  always #5 CLK = ~CLK;

  multicycle_control_unit u_dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO_Flag(ZERO_Flag),
    .MEM_READY(MEM_READY), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .PCSrc(PCSrc), .PCEn(PCEn),
    .ILLEGAL_OP(ILLEGAL_OP), .STATE(STATE), .INSTR_COUNT(INSTR_COUNT)
  );

  multicycle_control_unit #(.COUNT_WIDTH(4)) u_dut_w4 (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO_Flag(ZERO_Flag),
    .MEM_READY(MEM_READY), .IorD(s_iord), .MemWrite(s_memwrite), .IRWrite(s_irwrite),
    .RegDst(s_regdst), .MemtoReg(s_memtoreg), .RegWrite(s_regwrite), .ALUSrcA(s_srca),
    .ALUSrcB(s_srcb), .ALU_Control(s_alu), .PCSrc(s_pcsrc), .PCEn(s_pcen),
    .ILLEGAL_OP(s_ill), .STATE(s_state), .INSTR_COUNT(s_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
  endfunction

  // Expected control word {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALU_Control,PCSrc,PCEn}
  function automatic logic [14:0] exp_ctrl(input int ph, input logic mr, input logic z, input logic [5:0] fn);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen;
    logic [1:0] sb, pcs;
    logic [2:0] alu;
    iord = 1'b0; mw = 1'b0; irw = 1'b0; rd = 1'b0; m2r = 1'b0; rw = 1'b0; sa = 1'b0; pcen = 1'b0;
    sb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (ph)
      P_F:    begin sb = 2'b01; irw = mr; pcen = mr; end
      P_D:    sb = 2'b11;
      P_MA:   begin sa = 1'b1; sb = 2'b10; end
      P_MR:   iord = 1'b1;
      P_MWB:  begin m2r = 1'b1; rw = 1'b1; end
      P_MW:   begin iord = 1'b1; mw = 1'b1; end
      P_EX:   begin sa = 1'b1; alu = fn_tab.exists(fn) ? fn_tab[fn] : 3'b011; end
      P_AWB:  begin rd = 1'b1; rw = 1'b1; end
      P_BR:   begin sa = 1'b1; alu = 3'b100; pcs = 2'b01; pcen = z; end
      P_AE:   begin sa = 1'b1; sb = 2'b10; end
      P_AIWB: rw = 1'b1;
      P_J:    begin pcs = 2'b10; pcen = 1'b1; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, sa, sb, alu, pcs, pcen};
  endfunction

  function automatic phase_t mk(input int ph, input logic mr);
    phase_t p;
    p.ph = ph;
    p.mr = mr;
    return p;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Run one instruction from the negedge that starts its FETCH; optional reset at phase abort_at
  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm, input int abort_at);
    logic illegal;
    logic [14:0] got;
    illegal = (kind == K_ILL) || (kind == K_R && !fn_tab.exists(fn));
    q.delete();
    for (int i = 0; i < wf; i++) q.push_back(mk(P_F, 1'b0));
    q.push_back(mk(P_F, 1'b1));
    q.push_back(mk(P_D, rbit()));
    case (kind)
      K_LW: begin
        q.push_back(mk(P_MA, rbit()));
        for (int i = 0; i < wm; i++) q.push_back(mk(P_MR, 1'b0));
        q.push_back(mk(P_MR, 1'b1));
        q.push_back(mk(P_MWB, rbit()));
      end
      K_SW: begin
        q.push_back(mk(P_MA, rbit()));
        for (int i = 0; i < wm; i++) q.push_back(mk(P_MW, 1'b0));
        q.push_back(mk(P_MW, 1'b1));
      end
      K_R: begin
        q.push_back(mk(P_EX, rbit()));
        if (!illegal) q.push_back(mk(P_AWB, rbit()));
      end
      K_BEQ:  q.push_back(mk(P_BR, rbit()));
      K_ADDI: begin q.push_back(mk(P_AE, rbit())); q.push_back(mk(P_AIWB, rbit())); end
      K_J:    q.push_back(mk(P_J, rbit()));
      default: ;
    endcase
    for (int i = 0; i < q.size(); i++) begin
      OPCODE    = op;
      FUNCT     = fn;
      MEM_READY = q[i].mr;
      ZERO_Flag = (q[i].ph == P_BR) ? z : rbit();
      #1;
      got = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALU_Control, PCSrc, PCEn};
      check_eq("state", 32'(STATE), 32'(q[i].ph));
      check_eq("ctrl", 32'(got), 32'(exp_ctrl(q[i].ph, q[i].mr, ZERO_Flag, fn)));
      check_eq("illegal_op", 32'(ILLEGAL_OP), 32'(ill_pending));
      check_eq("count", INSTR_COUNT, exp_count);
      check_eq("count_w4", 32'(s_count), 32'(exp_count[3:0]));
      check_eq("state_w4", 32'(s_state), 32'(q[i].ph));
      ill_pending = 1'b0;
      if (i == abort_at) begin
        #2;
        MEM_READY = 1'b1;
        RST = 1'b1;
        #1;
        check_eq("rst_state", 32'(STATE), 32'(P_F));
        check_eq("rst_enables", 32'({IRWrite, PCEn, MemWrite, RegWrite}), 32'd0);
        check_eq("rst_count", INSTR_COUNT, 32'd0);
        check_eq("rst_illegal", 32'(ILLEGAL_OP), 32'd0);
        @(negedge CLK);
        #1;
        check_eq("rst_hold_state", 32'(STATE), 32'(P_F));
        check_eq("rst_hold_enables", 32'({IRWrite, PCEn, MemWrite, RegWrite}), 32'd0);
        RST = 1'b0;
        exp_count = 32'd0;
        ill_pending = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    if (illegal) ill_pending = 1'b1;
    else         exp_count = exp_count + 32'd1;
  endtask

  function automatic logic [5:0] op_of(input int kind);
    logic [5:0] op;
    case (kind)
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_R:    op = 6'b000000;
      K_BEQ:  op = 6'b000100;
      K_ADDI: op = 6'b001000;
      K_J:    op = 6'b000010;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (is_legal_op(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  initial begin
    logic [5:0] legal_fn [6];
    logic [5:0] fn;
    int kind;
    fn_tab[6'b100000] = 3'b010;
    fn_tab[6'b100010] = 3'b100;
    fn_tab[6'b100100] = 3'b000;
    fn_tab[6'b100101] = 3'b001;
    fn_tab[6'b101010] = 3'b110;
    fn_tab[6'b011000] = 3'b101;
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};

    // Power-on reset with MEM_READY high so ungated enables would show
    RST = 1'b1; OPCODE = 6'd0; FUNCT = 6'd0; ZERO_Flag = 1'b1; MEM_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check_eq("por_state", 32'(STATE), 32'(P_F));
    check_eq("por_enables", 32'({IRWrite, PCEn, MemWrite, RegWrite}), 32'd0);
    check_eq("por_count", INSTR_COUNT, 32'd0);
    check_eq("por_illegal", 32'(ILLEGAL_OP), 32'd0);
    RST = 1'b0;

    // Directed cases
    run_instr(K_LW,  6'b100011, 6'b000111, 1'b0, 2, 2, -1);
    run_instr(K_R,   6'b000000, 6'b100010, 1'b0, 0, 0, -1);
    run_instr(K_R,   6'b000000, 6'b101010, 1'b0, 0, 0, -1);
    run_instr(K_BEQ, 6'b000100, 6'b000000, 1'b1, 0, 0, -1);
    run_instr(K_BEQ, 6'b000100, 6'b000000, 1'b0, 0, 0, -1);
    run_instr(K_ILL, 6'b111111, 6'b100000, 1'b0, 0, 0, -1);
    run_instr(K_R,   6'b000000, 6'b000000, 1'b0, 0, 0, -1);
    run_instr(K_ADDI,6'b001000, 6'b010101, 1'b0, 1, 0, -1);
    run_instr(K_SW,  6'b101011, 6'b000000, 1'b0, 0, 3, -1);
    run_instr(K_J,   6'b000010, 6'b000000, 1'b0, 0, 0, -1);
    // Reset while waiting in MEMREAD (phase index 3 with no fetch wait)
    run_instr(K_LW,  6'b100011, 6'b000000, 1'b0, 0, 3, 3);
    // Enough jumps to wrap the 4-bit counter
    for (int i = 0; i < 17; i++) run_instr(K_J, 6'b000010, 6'b000000, 1'b0, 0, 0, -1);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 6));
      if ($urandom_range(0, 4) != 0) fn = legal_fn[$urandom_range(0, 5)];
      else                           fn = 6'($urandom_range(0, 63));
      run_instr(kind, op_of(kind), fn, rbit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
